reorder_buffer: RTL

- Circular reorder buffer that sits directly downstream of issue/rename and upstream of the architectural register file.
- Allocates a tag for each issued instruction and captures results from the common data bus.
- Retires entries in program order, driving the register file's commit interface (run_upd, commit_rd, res, head) and its branch-flush input (reset).
- Tag 0 is reserved to mean "no producer"; valid tags are 1..DEPTH.

---
 rtl/reorder_buffer_if.sv | 54 +++++
 rtl/reorder_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Bundle between issue/rename, the CDB, operand forwarding and the
// architectural register file for the reorder buffer.
// master: the surrounding pipeline. slave: the reorder buffer.
interface reorder_buffer_if #(
    parameter int TAG_W = 5
);
    // Issue: iss_valid is a request. It is taken on a rising clk edge when
    // rdy is high, full is low and flush is low. Otherwise it is dropped with
    // no retry. A taken issue receives the tag shown on tail in that cycle.
    logic             iss_valid;
    logic             iss_rd_hv;
    logic [4:0]       iss_rd;
    logic             iss_is_br;
    logic [TAG_W-1:0] tail;
    logic             full;

    // Common data bus writeback
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_value;
    logic             wb_mispred;
    logic [31:0]      wb_target;

    // Operand-forward lookup
    logic [TAG_W-1:0] qry_tag;
    logic             qry_ready;
    logic [31:0]      qry_value;

    // Register file commit and flush
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_res;
    logic [TAG_W-1:0] commit_tag;
    logic             flush;
    logic [31:0]      flush_pc;

    modport master (
        output iss_valid, iss_rd_hv, iss_rd, iss_is_br,
        output wb_valid, wb_tag, wb_value, wb_mispred, wb_target,
        output qry_tag,
        input  tail, full, qry_ready, qry_value,
        input  commit_valid, commit_rd, commit_res, commit_tag,
        input  flush, flush_pc
    );

    modport slave (
        input  iss_valid, iss_rd_hv, iss_rd, iss_is_br,
        input  wb_valid, wb_tag, wb_value, wb_mispred, wb_target,
        input  qry_tag,
        output tail, full, qry_ready, qry_value,
        output commit_valid, commit_rd, commit_res, commit_tag,
        output flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer. It allocates tags 1..DEPTH at issue and captures
// CDB results. It retires one entry per cycle in program order and flushes
// when a mispredicted branch retires. Tag 0 means "no producer".
// Optional feature macro: ROB_WB_BYPASS_EN. When defined, a writeback that
// targets the head entry commits at the same edge, and qry_* forwards any
// same-cycle writeback.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rdy,
    reorder_buffer_if.slave bus
);
    localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_LAST  = TAG_W'(DEPTH);

    // Per-entry state. Index 0 exists only so tags index directly; it never
    // becomes valid.
    logic [DEPTH:0] valid_q, ready_q, is_br_q, mispred_q;
    logic [4:0]     rd_q     [0:DEPTH];
    logic [31:0]    value_q  [0:DEPTH];
    logic [31:0]    target_q [0:DEPTH];

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;

    logic             commit_valid_q;
    logic [4:0]       commit_rd_q;
    logic [31:0]      commit_res_q;
    logic [TAG_W-1:0] commit_tag_q;
    logic             flush_q;
    logic [31:0]      flush_pc_q;

    logic        full_w, iss_acc, wb_hit, head_byp, qry_hit, qry_byp;
    logic        commit_fire, do_flush, hd_mispred;
    logic [31:0] hd_value, hd_target;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= TAG_LAST);
    endfunction

    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
    endfunction

    // Issue/writeback qualification, head view (optionally bypassed) and commit decision
    always_comb begin
        full_w  = (count_q == TAG_LAST);
        iss_acc = bus.iss_valid && !full_w && !flush_q;
        wb_hit  = bus.wb_valid && tag_ok(bus.wb_tag) && valid_q[bus.wb_tag];
`ifdef ROB_WB_BYPASS_EN
        head_byp = wb_hit && (bus.wb_tag == head_q);
        qry_byp  = wb_hit && (bus.wb_tag == bus.qry_tag);
`else
        head_byp = 1'b0;
        qry_byp  = 1'b0;
`endif
        hd_value    = head_byp ? bus.wb_value   : value_q[head_q];
        hd_mispred  = head_byp ? bus.wb_mispred : mispred_q[head_q];
        hd_target   = head_byp ? bus.wb_target  : target_q[head_q];
        commit_fire = valid_q[head_q] && (ready_q[head_q] || head_byp);
        do_flush    = commit_fire && is_br_q[head_q] && hd_mispred;
    end

    // Next-state for head/tail pointers and occupancy count
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (iss_acc)     tail_d = next_tag(tail_q);
        if (commit_fire) head_d = next_tag(head_q);
        case ({iss_acc, commit_fire})
            2'b10:   count_d = count_q + TAG_FIRST;
            2'b01:   count_d = count_q - TAG_FIRST;
            default: count_d = count_q;
        endcase
        if (do_flush) begin
            head_d  = TAG_FIRST;
            tail_d  = TAG_FIRST;
            count_d = '0;
        end
    end

    // Pointer, count and registered commit/flush outputs; rdy low freezes all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= TAG_FIRST;
            tail_q         <= TAG_FIRST;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_res_q   <= '0;
            commit_tag_q   <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy) begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_fire;
            flush_q        <= do_flush;
            if (commit_fire) begin
                commit_rd_q  <= rd_q[head_q];
                commit_res_q <= hd_value;
                commit_tag_q <= head_q;
            end
            if (do_flush) flush_pc_q <= hd_target;
        end
    end

    // Entry status bits; a flush wipes every entry and discards same-cycle issue/writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            ready_q   <= '0;
            is_br_q   <= '0;
            mispred_q <= '0;
        end else if (rdy) begin
            if (do_flush) begin
                valid_q <= '0;
                ready_q <= '0;
            end else begin
                if (wb_hit) begin
                    ready_q[bus.wb_tag]   <= 1'b1;
                    mispred_q[bus.wb_tag] <= bus.wb_mispred;
                end
                if (iss_acc) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    is_br_q[tail_q] <= bus.iss_is_br;
                end
                if (commit_fire) begin
                    valid_q[head_q] <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end
            end
        end
    end

    // Entry payload; only read while the matching valid/ready bits are set, so no reset
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (wb_hit) begin
                value_q[bus.wb_tag]  <= bus.wb_value;
                target_q[bus.wb_tag] <= bus.wb_target;
            end
            if (iss_acc) rd_q[tail_q] <= bus.iss_rd_hv ? bus.iss_rd : 5'd0;
        end
    end

    // Operand-forward lookup over held state (plus same-cycle writeback when bypassing)
    always_comb begin
        qry_hit       = tag_ok(bus.qry_tag) && valid_q[bus.qry_tag];
        bus.qry_ready = qry_hit && (ready_q[bus.qry_tag] || qry_byp);
        bus.qry_value = '0;
        if (qry_hit) bus.qry_value = qry_byp ? bus.wb_value : value_q[bus.qry_tag];
    end

    assign bus.tail         = tail_q;
    assign bus.full         = full_w;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_res   = commit_res_q;
    assign bus.commit_tag   = commit_tag_q;
    assign bus.flush        = flush_q;
    assign bus.flush_pc     = flush_pc_q;
endmodule
